// File: rtl/imem_fetch_ctrl.sv
// Instruction fetch sequencer: walks a fetch PC over the combinational imem,
// buffers {pc, word} pairs in a small prefetch FIFO, and hands them to decode.
module imem_fetch_ctrl #(
  parameter int            n         = 32,
  parameter int            r         = 6,
  parameter int            DEPTH     = 4,
  parameter logic [r-1:0]  RESET_PC  = '0,
  parameter logic [n-1:0]  HALT_WORD = {n{1'b1}}
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         enable,
  output logic [r-1:0] imem_addr,
  input  logic [n-1:0] imem_readdata,
  input  logic         redirect_valid,
  input  logic [r-1:0] redirect_addr,
  output logic         instr_valid,
  input  logic         instr_ready,
  output logic [n-1:0] instr,
  output logic [r-1:0] instr_pc,
  output logic         halted
);

  localparam int            AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
  localparam logic          ST_FETCH  = 1'b0;
  localparam logic          ST_HALTED = 1'b1;

  typedef struct packed {
    logic [r-1:0] pc;
    logic [n-1:0] word;
  } fifo_ent_t;

  fifo_ent_t [DEPTH-1:0] fifo_q;
  logic [r-1:0]          fetch_pc;
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic [AW:0]           count;
  logic                  state;
  logic                  pop;
  logic                  push;

  assign imem_addr   = fetch_pc;
  assign instr_valid = (count != '0);
  assign instr       = fifo_q[rd_ptr].word;
  assign instr_pc    = fifo_q[rd_ptr].pc;
  assign halted      = (state == ST_HALTED);

  // A simultaneous pop frees a slot, so a full FIFO can still accept a word.
  assign pop  = instr_valid & instr_ready;
  assign push = (state == ST_FETCH) & enable & ~redirect_valid &
                ((count < FULL_CNT) | pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc <= RESET_PC;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      state    <= ST_FETCH;
      fifo_q   <= '0;
    end else if (redirect_valid) begin
      // Storage is left stale; count==0 hides it until new words arrive.
      fetch_pc <= redirect_addr;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      state    <= ST_FETCH;
    end else begin
      if (push) begin
        fifo_q[wr_ptr] <= '{pc: fetch_pc, word: imem_readdata};
        wr_ptr         <= wr_ptr + 1'b1;
        fetch_pc       <= fetch_pc + 1'b1;
        if (imem_readdata == HALT_WORD) state <= ST_HALTED;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Bench for imem_fetch_ctrl: directed vector table, corner-case sequences and
// randomized traffic checked against a queue-based reference model.
module tb_imem_fetch_ctrl;

  localparam int DEPTH = 4;
  localparam logic [31:0] HALT = 32'hFFFF_FFFF;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic [5:0]  imem_addr;
  logic [31:0] imem_readdata;
  logic        redirect_valid = 1'b0;
  logic [5:0]  redirect_addr = '0;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic [31:0] instr;
  logic [5:0]  instr_pc;
  logic        halted;

  logic [31:0] imem [64];
  assign imem_readdata = imem[imem_addr];

  always #5 clk = ~clk;

  imem_fetch_ctrl dut (
    .clk(clk), .rst_n(rst_n), .enable(enable),
    .imem_addr(imem_addr), .imem_readdata(imem_readdata),
    .redirect_valid(redirect_valid), .redirect_addr(redirect_addr),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr(instr), .instr_pc(instr_pc), .halted(halted)
  );

  int errs = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a plain queue of fetched {pc, word} records.
  typedef struct { int pc; logic [31:0] w; } ent_t;
  ent_t m_q[$];
  int   m_fpc;
  bit   m_halt;

  task automatic model_reset();
    m_q.delete();
    m_fpc  = 0;
    m_halt = 0;
  endtask

  task automatic model_step(input bit en, input bit rdy, input bit rv, input int ra);
    if (rv) begin
      m_q.delete();
      m_fpc  = ra;
      m_halt = 0;
    end else begin
      if (rdy && m_q.size() > 0) void'(m_q.pop_front());
      if (!m_halt && en && m_q.size() < DEPTH) begin
        ent_t e;
        e.pc = m_fpc;
        e.w  = imem[m_fpc];
        m_q.push_back(e);
        if (e.w == HALT) m_halt = 1;
        m_fpc = (m_fpc + 1) % 64;
      end
    end
  endtask

  task automatic model_check();
    chk("model_valid", {31'd0, instr_valid}, {31'd0, m_q.size() != 0});
    chk("model_addr", {26'd0, imem_addr}, m_fpc);
    chk("model_halted", {31'd0, halted}, {31'd0, m_halt});
    if (m_q.size() != 0) begin
      chk("model_instr", instr, m_q[0].w);
      chk("model_pc", {26'd0, instr_pc}, m_q[0].pc);
    end
  endtask

  // One clock with the model in lockstep; starts and ends at a falling edge.
  task automatic cyc(input bit en, input bit rdy, input bit rv, input int ra);
    enable = en; instr_ready = rdy; redirect_valid = rv; redirect_addr = 6'(ra);
    #1;
    model_step(en, rdy, rv, ra);
    @(posedge clk);
    @(negedge clk);
    model_check();
  endtask

  task automatic do_reset();
    enable = 0; instr_ready = 0; redirect_valid = 0;
    rst_n = 0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1;
  endtask

  typedef struct {
    logic en, rdy, rv;
    logic [5:0] ra;
    logic ev;
    logic [31:0] ei;
    logic [5:0] ep, ea;
  } vec_t;

  vec_t vt[12];

  initial begin
    int got_pc[$];
    for (int i = 0; i < 64; i++) imem[i] = 32'h1000_0000 + i;

    //        en rdy rv  ra   valid instr          pc  addr
    vt[0]  = '{1, 1, 0, 6'd0,  1, 32'h1000_0000, 0,  1};
    vt[1]  = '{1, 1, 0, 6'd0,  1, 32'h1000_0001, 1,  2};
    vt[2]  = '{1, 1, 0, 6'd0,  1, 32'h1000_0002, 2,  3};
    vt[3]  = '{0, 1, 0, 6'd0,  0, 32'h0,         0,  3};
    vt[4]  = '{1, 0, 0, 6'd0,  1, 32'h1000_0003, 3,  4};
    vt[5]  = '{1, 0, 0, 6'd0,  1, 32'h1000_0003, 3,  5};
    vt[6]  = '{1, 0, 0, 6'd0,  1, 32'h1000_0003, 3,  6};
    vt[7]  = '{1, 0, 0, 6'd0,  1, 32'h1000_0003, 3,  7};
    vt[8]  = '{1, 0, 0, 6'd0,  1, 32'h1000_0003, 3,  7};
    vt[9]  = '{1, 1, 0, 6'd0,  1, 32'h1000_0004, 4,  8};
    vt[10] = '{0, 0, 1, 6'd20, 0, 32'h0,         0,  20};
    vt[11] = '{1, 1, 0, 6'd0,  1, 32'h1000_0014, 20, 21};

    // Reset state, sampled while rst_n is low.
    rst_n = 0;
    #7;
    chk("rst_valid", {31'd0, instr_valid}, 0);
    chk("rst_addr", {26'd0, imem_addr}, 0);
    chk("rst_instr", instr, 0);
    chk("rst_pc", {26'd0, instr_pc}, 0);
    chk("rst_halted", {31'd0, halted}, 0);
    @(negedge clk);
    rst_n = 1;

    for (int i = 0; i < 12; i++) begin
      enable = vt[i].en; instr_ready = vt[i].rdy;
      redirect_valid = vt[i].rv; redirect_addr = vt[i].ra;
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("vec%0d_valid", i), {31'd0, instr_valid}, {31'd0, vt[i].ev});
      chk($sformatf("vec%0d_addr", i), {26'd0, imem_addr}, {26'd0, vt[i].ea});
      chk($sformatf("vec%0d_halted", i), {31'd0, halted}, 0);
      if (vt[i].ev) begin
        chk($sformatf("vec%0d_instr", i), instr, vt[i].ei);
        chk($sformatf("vec%0d_pc", i), {26'd0, instr_pc}, {26'd0, vt[i].ep});
      end
    end

    // Backpressure: fill, then drain in order while refilling.
    do_reset();
    for (int k = 0; k < 8; k++) cyc(1, 0, 0, 0);
    chk("bp_addr_stuck", {26'd0, imem_addr}, 4);
    chk("bp_head_instr", instr, 32'h1000_0000);
    chk("bp_head_pc", {26'd0, instr_pc}, 0);
    for (int k = 0; k < 6; k++) begin
      chk("bp_order_valid", {31'd0, instr_valid}, 1);
      chk("bp_order_pc", {26'd0, instr_pc}, k);
      cyc(1, 1, 0, 0);
    end

    // Redirect while full, head popped on the redirect cycle.
    chk("rd_full_valid", {31'd0, instr_valid}, 1);
    cyc(1, 1, 1, 20);
    chk("rd_flush_valid", {31'd0, instr_valid}, 0);
    chk("rd_flush_addr", {26'd0, imem_addr}, 20);
    cyc(1, 1, 0, 0);
    chk("rd_new_pc", {26'd0, instr_pc}, 20);
    chk("rd_new_instr", instr, 32'h1000_0014);

    // Address wrap 63 -> 0.
    cyc(1, 1, 1, 62);
    for (int k = 0; k < 4; k++) begin
      int epc;
      epc = (62 + k) % 64;
      cyc(1, 1, 0, 0);
      chk("wrap_pc", {26'd0, instr_pc}, epc);
      chk("wrap_instr", instr, 32'h1000_0000 + epc);
    end

    // Halt on word 5, then restart by redirect.
    do_reset();
    imem[5] = HALT;
    for (int k = 0; k < 12; k++) begin
      if (instr_valid) got_pc.push_back(instr_pc);
      cyc(1, 1, 0, 0);
    end
    chk("halt_count", got_pc.size(), 6);
    for (int k = 0; k < got_pc.size() && k < 6; k++) chk("halt_order", got_pc[k], k);
    chk("halt_flag", {31'd0, halted}, 1);
    chk("halt_addr", {26'd0, imem_addr}, 6);
    chk("halt_drained", {31'd0, instr_valid}, 0);
    imem[5] = 32'h1000_0005;
    cyc(1, 1, 1, 0);
    chk("halt_clear", {31'd0, halted}, 0);
    cyc(1, 1, 0, 0);
    chk("halt_restart_pc", {26'd0, instr_pc}, 0);
    chk("halt_restart_valid", {31'd0, instr_valid}, 1);

    // Asynchronous reset between clock edges.
    for (int k = 0; k < 5; k++) cyc(1, 0, 0, 0);
    #2;
    rst_n = 0;
    #1;
    chk("areset_valid", {31'd0, instr_valid}, 0);
    chk("areset_addr", {26'd0, imem_addr}, 0);
    chk("areset_halted", {31'd0, halted}, 0);
    model_reset();
    @(negedge clk);
    rst_n = 1;
    cyc(1, 1, 0, 0);
    chk("areset_restart_pc", {26'd0, instr_pc}, 0);
    cyc(1, 1, 0, 0);
    chk("areset_restart_pc1", {26'd0, instr_pc}, 1);

    // Randomized traffic with occasional halt words and redirects.
    do_reset();
    for (int i = 0; i < 64; i++)
      imem[i] = ($urandom_range(0, 15) == 0) ? HALT : $urandom;
    for (int k = 0; k < 600; k++) begin
      bit en, rdy, rv;
      en  = ($urandom_range(0, 7) != 0);
      rdy = ($urandom_range(0, 2) != 0);
      rv  = ($urandom_range(0, 24) == 0) || (m_halt && $urandom_range(0, 3) == 0);
      cyc(en, rdy, rv, $urandom_range(0, 63));
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
